mem_access_unit: RTL and testbench

MEM-stage data-memory access unit for the mini RISC-V pipeline. It sits directly after the EX/MEM pipeline register and consumes its memory-control outputs (memRead, memWrite, maskMode, sext) together with the ALU address and store data. It runs a request/grant/response handshake to the data-memory bus and generates byte enables and store-data lane replication. Load results are extracted and sign- or zero-extended for MEM/WB, and `stall` holds the pipeline while a bus transaction is outstanding.

---
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/grant/response bus handshake,
// byte-lane enables and store replication, load extraction and extension.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mask_mode,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic [1:0]  debug_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [1:0]  off_q, mode_q;
    logic        sext_q;
    logic        access, misaligned, start, timeout, load_done;
    logic [3:0]  be_next;
    logic [31:0] wdata_next, shifted, extracted;

    assign access = mem_read | mem_write;

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'hF;
        wdata_next = wdata;
        case (mask_mode)
            2'd0: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'd1: begin
                misaligned = addr[0];
                be_next    = 4'b0011 << addr[1:0];
                wdata_next = {2{wdata[15:0]}};
            end
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    assign start = (state == IDLE) && access && !misaligned;

    // Completion (gnt / rvalid) wins over a timeout landing on the same cycle.
    always_comb begin
        state_next  = state;
        timeout     = 1'b0;
        load_done   = 1'b0;
        bus_req     = (state == REQ);
        stall       = start || (state == REQ) || (state == RSP);
        misalign    = (state == IDLE) && access && misaligned;
        debug_state = state;
        case (state)
            IDLE: if (start) state_next = REQ;
            REQ: begin
                if (bus_gnt) begin
                    state_next = bus_we ? DONE : RSP;
                end else if (cnt == LAST_CNT) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end
            end
            RSP: begin
                if (bus_rvalid) begin
                    state_next = DONE;
                    load_done  = 1'b1;
                end else if (cnt == LAST_CNT) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign shifted = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        case (mode_q)
            2'd0:    extracted = sext_q ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'h0, shifted[7:0]};
            2'd1:    extracted = sext_q ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'h0, shifted[15:0]};
            default: extracted = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 8'd0;
            off_q     <= 2'd0;
            mode_q    <= 2'd0;
            sext_q    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            rdata     <= 32'd0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= timeout;
            if (start) begin
                cnt       <= 8'd0;
                off_q     <= addr[1:0];
                mode_q    <= mask_mode;
                sext_q    <= sext;
                bus_we    <= mem_write;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be_next;
                bus_wdata <= wdata_next;
            end else if (state == REQ || state == RSP) begin
                cnt <= cnt + 8'd1;
            end
            // Only loads touch rdata; a store timeout leaves the last load result.
            if (load_done)              rdata <= extracted;
            else if (timeout && !bus_we) rdata <= 32'd0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table plus randomized accesses, with
// hand-written timeout, misalignment and reset-during-transaction sequences.
module tb_mem_access_unit;
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_RSP = 2'd2, S_DONE = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, sext;
    logic [1:0]  mask_mode;
    logic [31:0] addr, wdata;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, rdata;
    logic [3:0]  bus_be;
    logic        stall, misalign, bus_err;
    logic [1:0]  debug_state;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  mode;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          gw;
        int          rw;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t        tbl[11];
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;
    int          n_tests, n_fail, err_pulses;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mask_mode(mask_mode), .sext(sext), .addr(addr), .wdata(wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .rdata(rdata), .stall(stall), .misalign(misalign),
        .bus_err(bus_err), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus_err) err_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t make_rand();
        vec_t        v;
        logic [31:0] r;
        logic [1:0]  o;
        logic [15:0] h;
        logic [7:0]  b;
        r      = $urandom;
        v.wr   = 1'($urandom_range(0, 1));
        v.rd   = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
        v.mode = 2'($urandom_range(0, 3));
        v.sx   = 1'($urandom_range(0, 1));
        o      = (v.mode == 2'd0) ? 2'($urandom_range(0, 3)) :
                 (v.mode == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
        v.addr   = {r[31:2], o};
        v.wdata  = $urandom;
        v.brdata = $urandom;
        v.gw     = $urandom_range(0, 1);
        v.rw     = $urandom_range(0, 1);
        v.baddr  = {r[31:2], 2'b00};
        case (o)
            2'd0: b = v.brdata[7:0];
            2'd1: b = v.brdata[15:8];
            2'd2: b = v.brdata[23:16];
            default: b = v.brdata[31:24];
        endcase
        h = o[1] ? v.brdata[31:16] : v.brdata[15:0];
        case (v.mode)
            2'd0: begin
                v.be     = (o == 2'd0) ? 4'b0001 : (o == 2'd1) ? 4'b0010 :
                           (o == 2'd2) ? 4'b0100 : 4'b1000;
                v.bwdata = {v.wdata[7:0], v.wdata[7:0], v.wdata[7:0], v.wdata[7:0]};
                v.rdata  = v.sx ? {{24{b[7]}}, b} : {24'h0, b};
            end
            2'd1: begin
                v.be     = o[1] ? 4'b1100 : 4'b0011;
                v.bwdata = {v.wdata[15:0], v.wdata[15:0]};
                v.rdata  = v.sx ? {{16{h[15]}}, h} : {16'h0, h};
            end
            default: begin
                v.be     = 4'hF;
                v.bwdata = v.wdata;
                v.rdata  = v.brdata;
            end
        endcase
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [31:0] exp_r;
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; mask_mode = v.mode; sext = v.sx;
        addr = v.addr; wdata = v.wdata;
        if (!v.wr) model_rdata = v.rdata;
        exp_q.push_back(model_rdata);
        #1;
        check("idle_state", 32'(debug_state), 32'(S_IDLE));
        check("idle_stall", 32'(stall), 32'd1);
        check("idle_misalign", 32'(misalign), 32'd0);
        for (int i = 0; i <= v.gw; i++) begin
            @(negedge clk);
            bus_gnt = (i == v.gw);
            #1;
            check("req_state", 32'(debug_state), 32'(S_REQ));
            check("req_bus_req", 32'(bus_req), 32'd1);
            check("req_stall", 32'(stall), 32'd1);
            check("bus_addr", bus_addr, v.baddr);
            check("bus_be", 32'(bus_be), 32'(v.be));
            check("bus_we", 32'(bus_we), 32'(v.wr));
            if (v.wr) check("bus_wdata", bus_wdata, v.bwdata);
        end
        if (!v.wr) begin
            for (int i = 0; i <= v.rw; i++) begin
                @(negedge clk);
                bus_gnt    = 1'b0;
                bus_rvalid = (i == v.rw);
                bus_rdata  = (i == v.rw) ? v.brdata : $urandom;
                #1;
                check("rsp_state", 32'(debug_state), 32'(S_RSP));
                check("rsp_stall", 32'(stall), 32'd1);
                check("rsp_bus_req", 32'(bus_req), 32'd0);
            end
        end
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        check("done_state", 32'(debug_state), 32'(S_DONE));
        check("done_stall", 32'(stall), 32'd0);
        exp_r = exp_q.pop_front();
        check("rdata", rdata, exp_r);
    endtask

    initial begin
        int cyc;
        n_tests = 0; n_fail = 0; err_pulses = 0;
        model_rdata = 32'd0;
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mask_mode = 2'd0; sext = 1'b0;
        addr = 32'd0; wdata = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;

        //           rd    wr    mode  sx    addr   wdata         brdata        gw rw be       baddr  bwdata        rdata
        tbl[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'hF,    32'h100, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h203, 32'h0,        32'h80FFFFFF, 0, 2, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h203, 32'h0,        32'h80FFFFFF, 0, 2, 4'b1000, 32'h200, 32'h0,        32'h00000080};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h42,  32'h1234ABCD, 32'h0,        0, 0, 4'b1100, 32'h40,  32'hABCDABCD, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h5,   32'h000000A5, 32'h0,        1, 0, 4'b0010, 32'h4,   32'hA5A5A5A5, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h2,   32'h0,        32'h80011234, 1, 1, 4'b1100, 32'h0,   32'h0,        32'hFFFF8001};
        tbl[6]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0,   32'h0,        32'h0000F00D, 0, 0, 4'b0011, 32'h0,   32'h0,        32'h0000F00D};
        tbl[7]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h8,   32'h0,        32'h87654321, 0, 1, 4'hF,    32'h8,   32'h0,        32'h87654321};
        tbl[8]  = '{1'b0, 1'b1, 2'd3, 1'b0, 32'hC,   32'h11223344, 32'h0,        0, 0, 4'hF,    32'hC,   32'h11223344, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h10,  32'hCAFEF00D, 32'h0,        1, 0, 4'hF,    32'h10,  32'hCAFEF00D, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h1,   32'h0,        32'h00007F00, 0, 0, 4'b0010, 32'h0,   32'h0,        32'h0000007F};

        // Reset values
        #12;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_state", 32'(debug_state), 32'(S_IDLE));
        @(negedge clk); reset = 1'b0;

        for (int k = 0; k < 11; k++) run_vec(tbl[k]);

        // Misaligned word and half loads: no transaction, rdata untouched
        @(negedge clk);
        mem_read = 1'b1; mask_mode = 2'd2; addr = 32'h6; sext = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin mask_mode = 2'd1; addr = 32'h3; end
            #1;
            check("mis_misalign", 32'(misalign), 32'd1);
            check("mis_stall", 32'(stall), 32'd0);
            check("mis_bus_req", 32'(bus_req), 32'd0);
            check("mis_state", 32'(debug_state), 32'(S_IDLE));
            @(negedge clk);
        end
        mem_read = 1'b0;
        #1;
        check("mis_rdata", rdata, model_rdata);

        // Timeout: granted load, rvalid never arrives
        @(negedge clk);
        mem_read = 1'b1; mask_mode = 2'd2; addr = 32'h20;
        cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus_gnt = (c == 1);
            mem_read = 1'b1;
            #1;
            if (debug_state == S_DONE) begin cyc = c; break; end
        end
        bus_gnt = 1'b0; mem_read = 1'b0;
        check("to_cycles", 32'(cyc), 32'd5);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_rdata", rdata, 32'd0);
        check("to_bus_req", 32'(bus_req), 32'd0);
        model_rdata = 32'd0;
        @(negedge clk); #1;
        check("to_err_drop", 32'(bus_err), 32'd0);
        check("to_idle", 32'(debug_state), 32'(S_IDLE));
        check("to_err_pulses", 32'(err_pulses), 32'd1);

        for (int k = 0; k < 24; k++) run_vec(make_rand());
        check("rand_no_err", 32'(err_pulses), 32'd1);

        // Reset in REQ: bus_req falls without a clock edge
        @(negedge clk);
        mem_read = 1'b1; mask_mode = 2'd2; addr = 32'h30;
        @(negedge clk); #1;
        check("rreq_req_high", 32'(bus_req), 32'd1);
        #1 reset = 1'b1; mem_read = 1'b0;
        #1;
        check("rreq_req_low", 32'(bus_req), 32'd0);
        check("rreq_state", 32'(debug_state), 32'(S_IDLE));
        @(negedge clk); reset = 1'b0;

        // Reset in RSP, then a stale rvalid
        @(negedge clk);
        mem_read = 1'b1; mask_mode = 2'd2; addr = 32'h34;
        @(negedge clk); bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0; #1;
        check("rrsp_in_rsp", 32'(debug_state), 32'(S_RSP));
        #1 reset = 1'b1; mem_read = 1'b0;
        #1;
        check("rrsp_state", 32'(debug_state), 32'(S_IDLE));
        check("rrsp_rdata", rdata, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk); bus_rvalid = 1'b0; #1;
        check("rrsp_stale_rdata", rdata, 32'd0);
        check("rrsp_stale_state", 32'(debug_state), 32'(S_IDLE));
        check("rrsp_stale_req", 32'(bus_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
